// File: rtl/branch_fb_queue.sv
// In-order queue of per-branch prediction metadata between decode and ROB commit.
// The oldest entry is presented at commit as feedback for the tournament predictor.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef G_HISTORY_BITS
`define G_HISTORY_BITS 8
`endif

module branch_fb_queue #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int GH_BITS    = `G_HISTORY_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_valid,
    input  logic [ADDR_WIDTH-1:0]   push_pc,
    input  logic [GH_BITS-1:0]      push_ghistory,
    input  logic                    push_pred,
    input  logic                    push_pred_gshare,
    input  logic                    push_pred_2bit,
    output logic                    push_ready,
    input  logic                    commit_valid,
    input  logic                    commit_outcome,
    input  logic                    flush,
    output logic                    fb_valid,
    output logic [ADDR_WIDTH-1:0]   fb_pc,
    output logic [GH_BITS-1:0]      fb_ghistory,
    output logic                    fb_pred,
    output logic                    fb_pred_gshare,
    output logic                    fb_pred_2bit,
    output logic                    fb_outcome,
    output logic                    mispredict,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow_err,
    output logic                    underflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [GH_BITS-1:0]    ghistory;
        logic                  pred;
        logic                  pred_gshare;
        logic                  pred_2bit;
    } entry_t;

    entry_t             mem_r [DEPTH];
    logic [PTR_W-1:0]   head_r, tail_r;
    logic [CNT_W-1:0]   count_r;
    logic               push_ready_r;
    logic               overflow_r, underflow_r;

    entry_t             head_entry_s;
    logic               not_empty_s, squash_s, push_acc_s, pop_s;
    logic               overflow_set_s, underflow_set_s;
    logic [PTR_W-1:0]   head_next_s, tail_next_s;
    logic [CNT_W-1:0]   count_next_s;

    // Feedback decode, squash decision and next-state computation.
    always_comb begin
        head_entry_s    = mem_r[head_r];
        not_empty_s     = (count_r != {CNT_W{1'b0}});
        fb_valid        = commit_valid && not_empty_s;
        fb_pc           = head_entry_s.pc;
        fb_ghistory     = head_entry_s.ghistory;
        fb_pred         = head_entry_s.pred;
        fb_pred_gshare  = head_entry_s.pred_gshare;
        fb_pred_2bit    = head_entry_s.pred_2bit;
        fb_outcome      = commit_outcome;
        mispredict      = fb_valid && (head_entry_s.pred != commit_outcome);
        squash_s        = flush || mispredict;
        pop_s           = fb_valid;
        push_acc_s      = push_valid && push_ready_r && !squash_s;
        overflow_set_s  = push_valid && !push_ready_r && !squash_s;
        underflow_set_s = commit_valid && !not_empty_s;
        // A squash wipes the wrong-path entries, including any same-cycle push.
        if (squash_s) begin
            head_next_s  = {PTR_W{1'b0}};
            tail_next_s  = {PTR_W{1'b0}};
            count_next_s = {CNT_W{1'b0}};
        end else begin
            head_next_s  = head_r + (pop_s ? PTR_W'(1) : PTR_W'(0));
            tail_next_s  = tail_r + (push_acc_s ? PTR_W'(1) : PTR_W'(0));
            count_next_s = count_r + (push_acc_s ? CNT_W'(1) : CNT_W'(0))
                                   - (pop_s ? CNT_W'(1) : CNT_W'(0));
        end
    end

    // Pointer, occupancy, ready and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r       <= {PTR_W{1'b0}};
            tail_r       <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            push_ready_r <= 1'b1;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            head_r       <= head_next_s;
            tail_r       <= tail_next_s;
            count_r      <= count_next_s;
            push_ready_r <= (count_next_s != CNT_W'(DEPTH));
            overflow_r   <= overflow_r || overflow_set_s;
            underflow_r  <= underflow_r || underflow_set_s;
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push_acc_s && !rst) begin
            mem_r[tail_r] <= '{pc: push_pc, ghistory: push_ghistory, pred: push_pred,
                               pred_gshare: push_pred_gshare, pred_2bit: push_pred_2bit};
        end
    end

    assign push_ready    = push_ready_r;
    assign count         = count_r;
    assign overflow_err  = overflow_r;
    assign underflow_err = underflow_r;

endmodule
